// File: rtl/conv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sequencer_if
//  Purpose  : Bundles the control-side inputs and buffer/convolver/result
//             outputs of the convolution sequencer.
//  Signals  : i_valid      column-word load pulse from the control FSM
//             i_SoP        Start-of-Process level
//             i_imgLength  image width in columns (0 encodes 2^ADDR_W)
//             o_wrEn/o_wrAddr     column-buffer write strobe / address
//             o_rdEn/o_rdAddr     column-buffer read strobe / address
//             o_convValid         3-column window ready for the convolver
//             o_outWrEn/o_outAddr result-memory write strobe / address
//             o_EOP               one-cycle end-of-process pulse
//             o_state             current sequencer state (debug/LEDs)
//  Modports : master = control side / environment, slave = sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface conv_sequencer_if #(
   parameter int ADDR_W = 10
) ();
   logic              i_valid;
   logic              i_SoP;
   logic [ADDR_W-1:0] i_imgLength;
   logic              o_wrEn;
   logic [ADDR_W-1:0] o_wrAddr;
   logic              o_rdEn;
   logic [ADDR_W-1:0] o_rdAddr;
   logic              o_convValid;
   logic              o_outWrEn;
   logic [ADDR_W-1:0] o_outAddr;
   logic              o_EOP;
   logic [1:0]        o_state;

   modport master (
      output i_valid, i_SoP, i_imgLength,
      input  o_wrEn, o_wrAddr, o_rdEn, o_rdAddr, o_convValid,
             o_outWrEn, o_outAddr, o_EOP, o_state
   );

   modport slave (
      input  i_valid, i_SoP, i_imgLength,
      output o_wrEn, o_wrAddr, o_rdEn, o_rdAddr, o_convValid,
             o_outWrEn, o_outAddr, o_EOP, o_state
   );
endinterface
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sequencer
//  Purpose  : Loads image columns into the column buffer, then sweeps the
//             buffer in read order, flags complete 3-column windows for the
//             convolver, generates result-memory writes and returns a
//             one-cycle EOP pulse to the control block.
//  Ports    : i_CLK  clock (rising edge)
//             i_rst  synchronous active-high reset
//             bus    conv_sequencer_if.slave (control inputs, buffer,
//                    convolver and result-memory outputs, debug state)
//  Revision : 1.0  initial release
// ============================================================================
module conv_sequencer #(
   parameter int ADDR_W   = 10,
   parameter int CONV_LAT = 2,
   parameter int MEM_LAT  = 1
) (
   input wire              i_CLK,
   input wire              i_rst,
   conv_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int c_drain_len = MEM_LAT + CONV_LAT;
   localparam int c_drain_w   = $clog2(c_drain_len + 1);

   state_t               r_state, w_state_nxt;
   logic                 r_sop_prev;
   logic [ADDR_W-1:0]    r_wptr, w_wptr_nxt;
   logic [ADDR_W-1:0]    r_rptr, w_rptr_nxt;
   logic [ADDR_W-1:0]    r_last, w_last_nxt;
   logic [c_drain_w-1:0] r_drain_cnt, w_drain_cnt_nxt;
   logic                 r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0]    r_wr_addr, w_wr_addr_nxt;
   logic                 r_rd_en, w_rd_en_nxt;
   logic [ADDR_W-1:0]    r_rd_addr, w_rd_addr_nxt;
   logic [ADDR_W-1:0]    r_out_addr, w_out_addr_nxt;
   logic                 r_eop, w_eop_nxt;
   logic [MEM_LAT-1:0]   r_mem_dly;
   logic [CONV_LAT-1:0]  r_conv_dly;

   logic                 w_sop_rise;
   logic [ADDR_W-1:0]    w_len_last;
   logic                 w_win;
   logic                 w_conv_valid;
   logic                 w_out_wr_en;

   assign w_sop_rise   = bus.i_SoP & ~r_sop_prev;
   // Index of the last column; the 0 encoding wraps to all-ones, which is
   // exactly the last index of a full 2^ADDR_W-column image.
   assign w_len_last   = bus.i_imgLength - ADDR_W'(1);
   // A read of column >=2 completes a 3-column window once its data returns.
   assign w_win        = r_rd_en & (r_rd_addr >= ADDR_W'(2));
   assign w_conv_valid = r_mem_dly[MEM_LAT-1];
   assign w_out_wr_en  = r_conv_dly[CONV_LAT-1];

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_wptr_nxt      = r_wptr;
      w_rptr_nxt      = r_rptr;
      w_last_nxt      = r_last;
      w_drain_cnt_nxt = r_drain_cnt;
      w_wr_en_nxt     = 1'b0;
      w_wr_addr_nxt   = '0;
      w_rd_en_nxt     = 1'b0;
      w_rd_addr_nxt   = '0;
      w_eop_nxt       = 1'b0;
      w_out_addr_nxt  = w_out_wr_en ? r_out_addr + ADDR_W'(1) : r_out_addr;

      case (r_state)
         S_LOAD: begin
            if (bus.i_valid) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_wptr;
               w_wptr_nxt    = (r_wptr == w_len_last) ? '0 : r_wptr + ADDR_W'(1);
            end
            // The first read is issued on the entry edge so that column 0 is
            // on the bus in the very first RUN cycle.
            if (w_sop_rise) begin
               w_state_nxt    = S_RUN;
               w_last_nxt     = w_len_last;
               w_rd_en_nxt    = 1'b1;
               w_rd_addr_nxt  = '0;
               w_rptr_nxt     = ADDR_W'(1);
               w_out_addr_nxt = '0;
            end
         end
         S_RUN: begin
            if (r_rd_addr == r_last) begin
               w_state_nxt     = S_DRAIN;
               w_drain_cnt_nxt = '0;
            end else begin
               w_rd_en_nxt   = 1'b1;
               w_rd_addr_nxt = r_rptr;
               w_rptr_nxt    = r_rptr + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            // Covers buffer read latency plus convolver latency so the last
            // result write lands in the final DRAIN cycle.
            if (r_drain_cnt == c_drain_w'(c_drain_len - 1)) begin
               w_state_nxt = S_DONE;
               w_eop_nxt   = 1'b1;
            end else begin
               w_drain_cnt_nxt = r_drain_cnt + c_drain_w'(1);
            end
         end
         S_DONE: begin
            w_state_nxt     = S_LOAD;
            w_wptr_nxt      = '0;
            w_rptr_nxt      = '0;
            w_out_addr_nxt  = '0;
            w_drain_cnt_nxt = '0;
         end
         default: begin
            w_state_nxt = S_LOAD;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge i_CLK) begin
      if (i_rst) begin
         r_state     <= S_LOAD;
         r_sop_prev  <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_last      <= '0;
         r_drain_cnt <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_out_addr  <= '0;
         r_eop       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sop_prev  <= bus.i_SoP;
         r_wptr      <= w_wptr_nxt;
         r_rptr      <= w_rptr_nxt;
         r_last      <= w_last_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_rd_en     <= w_rd_en_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_out_addr  <= w_out_addr_nxt;
         r_eop       <= w_eop_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Delay lines: buffer read latency, then convolver latency
   // ------------------------------------------------------------------------
   generate
      if (MEM_LAT == 1) begin : g_mem_one
         always_ff @(posedge i_CLK) begin
            if (i_rst) r_mem_dly <= '0;
            else       r_mem_dly <= w_win;
         end
      end else begin : g_mem_multi
         always_ff @(posedge i_CLK) begin
            if (i_rst) r_mem_dly <= '0;
            else       r_mem_dly <= {r_mem_dly[MEM_LAT-2:0], w_win};
         end
      end

      if (CONV_LAT == 1) begin : g_conv_one
         always_ff @(posedge i_CLK) begin
            if (i_rst) r_conv_dly <= '0;
            else       r_conv_dly <= w_conv_valid;
         end
      end else begin : g_conv_multi
         always_ff @(posedge i_CLK) begin
            if (i_rst) r_conv_dly <= '0;
            else       r_conv_dly <= {r_conv_dly[CONV_LAT-2:0], w_conv_valid};
         end
      end
   endgenerate

   assign bus.o_wrEn      = r_wr_en;
   assign bus.o_wrAddr    = r_wr_addr;
   assign bus.o_rdEn      = r_rd_en;
   assign bus.o_rdAddr    = r_rd_addr;
   assign bus.o_convValid = w_conv_valid;
   assign bus.o_outWrEn   = w_out_wr_en;
   assign bus.o_outAddr   = r_out_addr;
   assign bus.o_EOP       = r_eop;
   assign bus.o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_sequencer
//  Purpose  : Self-checking bench for conv_sequencer. Expected traces come
//             from a cycle-offset model of a run (reads, windows, results,
//             EOP expressed relative to the first RUN cycle) and a simple
//             write-pointer model for the LOAD phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_sequencer;
   localparam int ADDR_W   = 10;
   localparam int CONV_LAT = 2;
   localparam int MEM_LAT  = 1;
   localparam int DEPTH    = 1 << ADDR_W;

   logic i_CLK = 1'b0;
   logic i_rst;
   int   total = 0;
   int   bad   = 0;
   int   m_wptr = 0;

   conv_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   conv_sequencer #(
      .ADDR_W  (ADDR_W),
      .CONV_LAT(CONV_LAT),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .i_CLK(i_CLK),
      .i_rst(i_rst),
      .bus  (bus)
   );

   always #5 i_CLK = ~i_CLK;

   task automatic sop_release;
      bus.i_SoP   = 1'b0;
      bus.i_valid = 1'b0;
      @(negedge i_CLK);
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      bus.i_valid = 1'b0; bus.i_SoP = 1'b0; bus.i_imgLength = ADDR_W'(5);
      repeat (2) @(negedge i_CLK);
      total += 9;
      if (bus.o_wrEn !== 1'b0)       begin bad++; $display("FAIL reset_wrEn got=%0b exp=0", bus.o_wrEn); end
      if (bus.o_wrAddr !== '0)       begin bad++; $display("FAIL reset_wrAddr got=%0d exp=0", bus.o_wrAddr); end
      if (bus.o_rdEn !== 1'b0)       begin bad++; $display("FAIL reset_rdEn got=%0b exp=0", bus.o_rdEn); end
      if (bus.o_rdAddr !== '0)       begin bad++; $display("FAIL reset_rdAddr got=%0d exp=0", bus.o_rdAddr); end
      if (bus.o_convValid !== 1'b0)  begin bad++; $display("FAIL reset_convValid got=%0b exp=0", bus.o_convValid); end
      if (bus.o_outWrEn !== 1'b0)    begin bad++; $display("FAIL reset_outWrEn got=%0b exp=0", bus.o_outWrEn); end
      if (bus.o_outAddr !== '0)      begin bad++; $display("FAIL reset_outAddr got=%0d exp=0", bus.o_outAddr); end
      if (bus.o_EOP !== 1'b0)        begin bad++; $display("FAIL reset_EOP got=%0b exp=0", bus.o_EOP); end
      if (bus.o_state !== 2'd0)      begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.o_state); end
      i_rst  = 1'b0;
      m_wptr = 0;
   endtask

   // n valid pulses in LOAD with random gaps; write address follows a
   // pointer that wraps to 0 after L-1.
   task automatic test_load_writes(input int code, input int n, input int gmin, input int gmax);
      int L, gap;
      logic [ADDR_W-1:0] ea;
      L = (code == 0) ? DEPTH : code;
      bus.i_imgLength = code[ADDR_W-1:0];
      for (int i = 0; i < n; i++) begin
         bus.i_valid = 1'b1;
         @(negedge i_CLK);
         bus.i_valid = 1'b0;
         ea = m_wptr[ADDR_W-1:0];
         total += 5;
         if (bus.o_wrEn !== 1'b1)   begin bad++; $display("FAIL load_wrEn i=%0d got=%0b exp=1", i, bus.o_wrEn); end
         if (bus.o_wrAddr !== ea)   begin bad++; $display("FAIL load_wrAddr i=%0d got=%0d exp=%0d", i, bus.o_wrAddr, ea); end
         if (bus.o_rdEn !== 1'b0)   begin bad++; $display("FAIL load_rdEn i=%0d got=%0b exp=0", i, bus.o_rdEn); end
         if (bus.o_outWrEn !== 1'b0 || bus.o_convValid !== 1'b0 || bus.o_EOP !== 1'b0)
                                    begin bad++; $display("FAIL load_quiet i=%0d got=%0b%0b%0b exp=000", i, bus.o_outWrEn, bus.o_convValid, bus.o_EOP); end
         if (bus.o_state !== 2'd0)  begin bad++; $display("FAIL load_state i=%0d got=%0d exp=0", i, bus.o_state); end
         m_wptr = (m_wptr == L - 1) ? 0 : m_wptr + 1;
         gap = $urandom_range(gmax, gmin);
         for (int j = 1; j < gap; j++) begin
            @(negedge i_CLK);
            total++;
            if (bus.o_wrEn !== 1'b0) begin bad++; $display("FAIL load_idle_wrEn i=%0d got=%0b exp=0", i, bus.o_wrEn); end
         end
      end
   endtask

   // SoP rising edge, then a full run checked cycle by cycle from the first
   // RUN cycle (k=0) until the cycle after DONE.
   task automatic test_run(input int code, input bit with_valid, input bit drop_sop);
      int L, fin, r, r2, tmp;
      logic [ADDR_W-1:0] exp_waddr, e_ra, e_oa;
      logic [1:0] e_st;
      bit e_rd, e_cv, e_ow, e_eop, e_wr;
      L   = (code == 0) ? DEPTH : code;
      fin = L + MEM_LAT + CONV_LAT;
      exp_waddr = m_wptr[ADDR_W-1:0];
      @(negedge i_CLK);
      bus.i_imgLength = code[ADDR_W-1:0];
      bus.i_SoP   = 1'b1;
      bus.i_valid = with_valid;
      for (int k = 0; k <= fin + 1; k++) begin
         @(negedge i_CLK);
         r  = k - MEM_LAT;
         r2 = k - MEM_LAT - CONV_LAT;
         e_rd  = (k < L);
         tmp   = k;      e_ra = tmp[ADDR_W-1:0];
         e_cv  = (r >= 2) && (r < L);
         e_ow  = (r2 >= 2) && (r2 < L);
         tmp   = r2 - 2; e_oa = tmp[ADDR_W-1:0];
         e_eop = (k == fin);
         e_wr  = (k == 0) && with_valid;
         e_st  = (k < L) ? 2'd1 : (k < fin) ? 2'd2 : (k == fin) ? 2'd3 : 2'd0;
         total += 6;
         if (bus.o_rdEn !== e_rd)       begin bad++; $display("FAIL run_rdEn L=%0d k=%0d got=%0b exp=%0b", L, k, bus.o_rdEn, e_rd); end
         if (bus.o_convValid !== e_cv)  begin bad++; $display("FAIL run_convValid L=%0d k=%0d got=%0b exp=%0b", L, k, bus.o_convValid, e_cv); end
         if (bus.o_outWrEn !== e_ow)    begin bad++; $display("FAIL run_outWrEn L=%0d k=%0d got=%0b exp=%0b", L, k, bus.o_outWrEn, e_ow); end
         if (bus.o_EOP !== e_eop)       begin bad++; $display("FAIL run_EOP L=%0d k=%0d got=%0b exp=%0b", L, k, bus.o_EOP, e_eop); end
         if (bus.o_state !== e_st)      begin bad++; $display("FAIL run_state L=%0d k=%0d got=%0d exp=%0d", L, k, bus.o_state, e_st); end
         if (bus.o_wrEn !== e_wr)       begin bad++; $display("FAIL run_wrEn L=%0d k=%0d got=%0b exp=%0b", L, k, bus.o_wrEn, e_wr); end
         if (e_rd) begin
            total++;
            if (bus.o_rdAddr !== e_ra)  begin bad++; $display("FAIL run_rdAddr L=%0d k=%0d got=%0d exp=%0d", L, k, bus.o_rdAddr, e_ra); end
         end
         if (e_ow) begin
            total++;
            if (bus.o_outAddr !== e_oa) begin bad++; $display("FAIL run_outAddr L=%0d k=%0d got=%0d exp=%0d", L, k, bus.o_outAddr, e_oa); end
         end
         if (e_wr) begin
            total++;
            if (bus.o_wrAddr !== exp_waddr) begin bad++; $display("FAIL run_wrAddr L=%0d got=%0d exp=%0d", L, bus.o_wrAddr, exp_waddr); end
         end
         // Inputs that must be ignored while the sweep is in progress.
         bus.i_valid = (k < fin) ? 1'($urandom_range(1, 0)) : 1'b0;
         if (k == 1) bus.i_imgLength = ADDR_W'($urandom);
         if (drop_sop && k == 2) bus.i_SoP = 1'b0;
      end
      m_wptr = 0;
   endtask

   task automatic test_sop_held;
      for (int i = 0; i < 8; i++) begin
         @(negedge i_CLK);
         total += 3;
         if (bus.o_state !== 2'd0) begin bad++; $display("FAIL held_state i=%0d got=%0d exp=0", i, bus.o_state); end
         if (bus.o_rdEn !== 1'b0)  begin bad++; $display("FAIL held_rdEn i=%0d got=%0b exp=0", i, bus.o_rdEn); end
         if (bus.o_EOP !== 1'b0)   begin bad++; $display("FAIL held_EOP i=%0d got=%0b exp=0", i, bus.o_EOP); end
      end
      sop_release;
   endtask

   task automatic test_same_cycle_sop;
      test_load_writes(7, 3, 1, 2);
      test_run(7, 1'b1, 1'b0);
      test_sop_held;
   endtask

   task automatic test_reset_midrun;
      @(negedge i_CLK);
      bus.i_imgLength = ADDR_W'(5); bus.i_SoP = 1'b1; bus.i_valid = 1'b0;
      @(negedge i_CLK);
      total += 2;
      if (bus.o_rdEn !== 1'b1 || bus.o_rdAddr !== ADDR_W'(0)) begin bad++; $display("FAIL mid_t0 got=%0b/%0d exp=1/0", bus.o_rdEn, bus.o_rdAddr); end
      if (bus.o_state !== 2'd1) begin bad++; $display("FAIL mid_t0_state got=%0d exp=1", bus.o_state); end
      @(negedge i_CLK);
      total++;
      if (bus.o_rdAddr !== ADDR_W'(1)) begin bad++; $display("FAIL mid_t1_rdAddr got=%0d exp=1", bus.o_rdAddr); end
      @(negedge i_CLK);
      i_rst = 1'b1; bus.i_SoP = 1'b0;
      @(negedge i_CLK);
      i_rst = 1'b0;
      total += 3;
      if ({bus.o_wrEn, bus.o_rdEn, bus.o_convValid, bus.o_outWrEn, bus.o_EOP} !== 5'b0)
         begin bad++; $display("FAIL mid_rst_strobes got=%05b exp=00000", {bus.o_wrEn, bus.o_rdEn, bus.o_convValid, bus.o_outWrEn, bus.o_EOP}); end
      if ({bus.o_wrAddr, bus.o_rdAddr, bus.o_outAddr} !== '0)
         begin bad++; $display("FAIL mid_rst_addrs got=%0d/%0d/%0d exp=0/0/0", bus.o_wrAddr, bus.o_rdAddr, bus.o_outAddr); end
      if (bus.o_state !== 2'd0) begin bad++; $display("FAIL mid_rst_state got=%0d exp=0", bus.o_state); end
      for (int i = 0; i < 10; i++) begin
         @(negedge i_CLK);
         total += 2;
         if (bus.o_EOP !== 1'b0)   begin bad++; $display("FAIL mid_no_EOP i=%0d got=%0b exp=0", i, bus.o_EOP); end
         if (bus.o_state !== 2'd0) begin bad++; $display("FAIL mid_idle_state i=%0d got=%0d exp=0", i, bus.o_state); end
      end
      m_wptr = 0;
      test_run(5, 1'b0, 1'b0);
      sop_release;
   endtask

   task automatic test_back_to_back;
      int code;
      for (int i = 0; i < 4; i++) begin
         code = $urandom_range(40, 3);
         test_load_writes(code, $urandom_range(5, 0), 1, 3);
         test_run(code, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
         sop_release;
      end
      // 0 encodes a full 2^ADDR_W-column image.
      test_load_writes(0, 3, 1, 2);
      test_run(0, 1'b0, 1'b1);
      sop_release;
   endtask

   initial begin
      bus.i_valid = 1'b0; bus.i_SoP = 1'b0; bus.i_imgLength = '0;
      i_rst = 1'b1;
      test_reset;
      test_load_writes(5, 5, 3, 3);
      test_run(5, 1'b0, 1'b0);
      sop_release;
      test_load_writes(4, 6, 1, 3);     // wraps 0,1,2,3,0,1
      test_run(2, 1'b0, 1'b1);
      sop_release;
      test_run(1, 1'b0, 1'b0);
      sop_release;
      test_same_cycle_sop;
      test_reset_midrun;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
